instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Upstream stage of the program memory in the microdatapath. It holds the program counter, drives the memory's read strobe, write strobe and address bus, and latches the returned 32-bit SPARC-format word into an instruction register for the decoder. It supports downstream stall, external PC redirect, and halt on the end-of-program word.

Parameters:
DATAWIDTH_BUS, 32, width of the address, data, PC and IR buses.
RESET_PC, 32'h0000_0800, PC value loaded on reset (first program word).
HALT_WORD, 32'h0000_0000, fetched word that stops fetching.

Ports:
CLOCK_50  input  1  system clock, rising edge.
RESET_InHigh  input  1  reset, asynchronous, active-high.
fetch_Stall_In  input  1  decoder not accepting; hold PC and IR.
fetch_Redirect_In  input  1  load PC from fetch_Target_In.
fetch_Target_In  input  DATAWIDTH_BUS  redirect target address.
fetch_MemData_In  input  DATAWIDTH_BUS  word returned by program memory (combinational, same cycle).
fetch_MemRD_Out  output  1  read strobe to program memory.
fetch_MemWR_Out  output  1  write strobe to program memory; constant 0.
fetch_Address_Out  output  DATAWIDTH_BUS  address to program memory; equals PC.
fetch_IR_Out  output  DATAWIDTH_BUS  latched instruction.
fetch_IRPC_Out  output  DATAWIDTH_BUS  address the IR word was fetched from.
fetch_IRValid_Out  output  1  IR holds a live instruction.
fetch_Halted_Out  output  1  unit is in HALT.

Behaviour:
- Clock and reset: one clock, CLOCK_50. RESET_InHigh is asynchronous and active-high.
- Reset values: state IDLE, PC=RESET_PC, IR=0, IRPC=0, IRValid=0, Halted=0.
- MemRD=0 during reset. MemWR=0 always.
- States:
  - IDLE: one cycle after reset release. MemRD=0. Always goes to FETCH.
  - FETCH: MemRD=1, Address=PC.
  - HALT: MemRD=0, Address=PC (held), Halted=1.
- Latency: the word is captured on the edge that ends the cycle in which its address is driven. IRValid rises on that same edge.
- FETCH, per edge, in priority order:
  1. Redirect=1: PC<=Target with bits [1:0] forced to 00; IRValid<=0 (squash); IR and IRPC hold. Overrides stall and halt detection.
  2. Stall=1: PC, IR, IRPC and IRValid hold. Address stays stable and MemRD stays 1.
  3. MemData==HALT_WORD: IR<=HALT_WORD, IRValid<=0, PC holds; go to HALT.
  4. Otherwise: IR<=MemData, IRPC<=PC, IRValid<=1, PC<=PC+4.
- PC arithmetic: modulo 2^DATAWIDTH_BUS. 0xFFFF_FFFC + 4 wraps to 0.
- HALT:
  - Stays in HALT until Redirect=1. Stall has no effect.
  - On Redirect: PC<=aligned Target, go to FETCH, IRValid stays 0.
- IDLE with Redirect=1: PC<=aligned Target, still go to FETCH.
- Reset asserted mid-operation, in any state: all registers go to their reset values immediately, without waiting for a clock edge.
- No combinational path from fetch_MemData_In to any output. All outputs except MemRD and Address are registered. MemRD and Address decode only state and PC.

Optional Feature:
STATIC_BRANCH_EN
- Defined: the unit decodes the unconditional branch "ba" in fetch_MemData_In: bits[31:30]=00, [28:25]=1000, [24:22]=010.
- Case 4 with "ba": next PC <= PC + (sign-extended disp22[21:0] << 2), not PC+4. The branch word is still delivered with IRValid=1. No delay slot.
- Redirect, stall and halt priorities are unchanged.
- Not defined: "ba" is an ordinary word. PC advances by 4 and the decoder resolves it by asserting fetch_Redirect_In.

Test Plan:
1. Reset, release, no stall -> one IDLE cycle with MemRD=0, then Address 0x800, 0x804, 0x808 on consecutive cycles; first IR=0x82802001 with IRPC=0x800 and IRValid=1.
2. Stall held 3 cycles while Address=0x80C -> Address stays 0x80C, IR stays 0x86802000, IRValid stays 1. On release, IR=0x88803FF6.
3. Stall=1 and Redirect=1 with Target=0x823 -> next cycle Address=0x820 and IRValid=0; following edge IR=0x82803800.
4. Run to 0x838, where the word is 0 -> Halted=1, MemRD=0, IRValid=0, Address holds 0x838. Then Redirect Target=0x800 -> fetch resumes at 0x800.
5. Assert RESET_InHigh asynchronously mid-cycle at PC=0x818 -> PC=0x800, IRValid=0 and MemRD=0 before the next clock edge.
6. Fetch 0x10BFFFFB at 0x834 -> with STATIC_BRANCH_EN, next Address=0x820; without it, next Address=0x838 followed by HALT.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Program-memory fetch stage: PC, read strobe/address, IR latch. Word captured on the edge ending its address cycle.
// Stall holds PC/IR with the address stable; redirect squashes; HALT_WORD halts. Optional `STATIC_BRANCH_EN follows "ba" at fetch.
module instruction_fetch_unit #(
  parameter int                       DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0] RESET_PC      = 32'h0000_0800,
  parameter logic [DATAWIDTH_BUS-1:0] HALT_WORD     = 32'h0000_0000
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_InHigh,
  input  logic                     fetch_Stall_In,
  input  logic                     fetch_Redirect_In,
  input  logic [DATAWIDTH_BUS-1:0] fetch_Target_In,
  input  logic [DATAWIDTH_BUS-1:0] fetch_MemData_In,
  output logic                     fetch_MemRD_Out,
  output logic                     fetch_MemWR_Out,
  output logic [DATAWIDTH_BUS-1:0] fetch_Address_Out,
  output logic [DATAWIDTH_BUS-1:0] fetch_IR_Out,
  output logic [DATAWIDTH_BUS-1:0] fetch_IRPC_Out,
  output logic                     fetch_IRValid_Out,
  output logic                     fetch_Halted_Out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [DATAWIDTH_BUS-1:0] PC_STEP    = DATAWIDTH_BUS'(4);
  localparam logic [DATAWIDTH_BUS-1:0] ALIGN_MASK = ~DATAWIDTH_BUS'(3);

  state_t                   state;
  logic [DATAWIDTH_BUS-1:0] pc;
  logic [DATAWIDTH_BUS-1:0] ir;
  logic [DATAWIDTH_BUS-1:0] irpc;
  logic                     ir_valid;
  logic                     halted;
  logic [DATAWIDTH_BUS-1:0] target_aligned;
  logic [DATAWIDTH_BUS-1:0] seq_pc;

  assign target_aligned = fetch_Target_In & ALIGN_MASK;

`ifdef STATIC_BRANCH_EN
  // "ba": op=00, cond=1000, op2=010; displacement is a signed word count.
  logic                     is_ba;
  logic [DATAWIDTH_BUS-1:0] ba_disp;

  assign is_ba   = (fetch_MemData_In[31:30] == 2'b00) &&
                   (fetch_MemData_In[28:25] == 4'b1000) &&
                   (fetch_MemData_In[24:22] == 3'b010);
  assign ba_disp = {{(DATAWIDTH_BUS-24){fetch_MemData_In[21]}}, fetch_MemData_In[21:0], 2'b00};
  assign seq_pc  = is_ba ? (pc + ba_disp) : (pc + PC_STEP);
`else
  assign seq_pc  = pc + PC_STEP;
`endif

  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      irpc     <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          if (fetch_Redirect_In) pc <= target_aligned;
        end
        S_FETCH: begin
          if (fetch_Redirect_In) begin
            pc       <= target_aligned;
            ir_valid <= 1'b0;
          end else if (fetch_Stall_In) begin
            // hold everything so the decoder sees the same IR next cycle
          end else if (fetch_MemData_In == HALT_WORD) begin
            ir       <= HALT_WORD;
            ir_valid <= 1'b0;
            halted   <= 1'b1;
            state    <= S_HALT;
          end else begin
            ir       <= fetch_MemData_In;
            irpc     <= pc;
            ir_valid <= 1'b1;
            pc       <= seq_pc;
          end
        end
        S_HALT: begin
          if (fetch_Redirect_In) begin
            pc     <= target_aligned;
            halted <= 1'b0;
            state  <= S_FETCH;
          end
        end
        default: begin
          state    <= S_IDLE;
          ir_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

  // Memory-side strobes decode only state and PC, never the returned data.
  assign fetch_MemRD_Out   = (state == S_FETCH);
  assign fetch_MemWR_Out   = 1'b0;
  assign fetch_Address_Out = pc;
  assign fetch_IR_Out      = ir;
  assign fetch_IRPC_Out    = irpc;
  assign fetch_IRValid_Out = ir_valid;
  assign fetch_Halted_Out  = halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational program-memory model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] mem_data;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] address;
  logic [31:0] ir;
  logic [31:0] irpc;
  logic        ir_valid;
  logic        halted;

  int tests_run = 0;
  int tests_failed = 0;

  instruction_fetch_unit dut (
    .CLOCK_50          (clk),
    .RESET_InHigh      (rst),
    .fetch_Stall_In    (stall),
    .fetch_Redirect_In (redirect),
    .fetch_Target_In   (target),
    .fetch_MemData_In  (mem_data),
    .fetch_MemRD_Out   (mem_rd),
    .fetch_MemWR_Out   (mem_wr),
    .fetch_Address_Out (address),
    .fetch_IR_Out      (ir),
    .fetch_IRPC_Out    (irpc),
    .fetch_IRValid_Out (ir_valid),
    .fetch_Halted_Out  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] prog(input logic [31:0] a);
    case (a)
      32'h0000_0800: prog = 32'h8280_2001;
      32'h0000_0804: prog = 32'h8480_2002;
      32'h0000_0808: prog = 32'h8680_2000;
      32'h0000_080C: prog = 32'h8880_3FF6;
      32'h0000_0810: prog = 32'h8A80_0005;
      32'h0000_0814: prog = 32'h8C80_0006;
      32'h0000_0818: prog = 32'h8E80_0007;
      32'h0000_081C: prog = 32'h9080_0008;
      32'h0000_0820: prog = 32'h8280_3800;
      32'h0000_0824: prog = 32'h8480_3801;
      32'h0000_0828: prog = 32'h8680_3802;
      32'h0000_082C: prog = 32'h8880_3803;
      32'h0000_0830: prog = 32'h8A80_3804;
      32'h0000_0834: prog = 32'h10BF_FFFB;
      32'hFFFF_FFFC: prog = 32'h0100_0000;
      default:       prog = 32'h0000_0000;
    endcase
  endfunction

  always_comb mem_data = prog(address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; target = 32'h0;
    #12;
    chk("rst_addr", address, 32'h800);
    chk("rst_ir", ir, 32'h0);
    chk("rst_irpc", irpc, 32'h0);
    chk("rst_irvalid", {31'b0, ir_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_memrd", {31'b0, mem_rd}, 32'h0);
    chk("rst_memwr", {31'b0, mem_wr}, 32'h0);

    // Release between edges; the following cycle is IDLE.
    tick(); rst = 1'b0;
    chk("idle_memrd", {31'b0, mem_rd}, 32'h0);
    tick();
    chk("f0_addr", address, 32'h800);
    chk("f0_memrd", {31'b0, mem_rd}, 32'h1);
    tick();
    chk("f1_addr", address, 32'h804);
    chk("f1_ir", ir, 32'h8280_2001);
    chk("f1_irpc", irpc, 32'h800);
    chk("f1_irvalid", {31'b0, ir_valid}, 32'h1);
    tick();
    chk("f2_addr", address, 32'h808);
    tick();
    chk("f3_addr", address, 32'h80C);
    chk("f3_ir", ir, 32'h8680_2000);

    // Stall for three edges.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", address, 32'h80C);
      chk("stall_ir", ir, 32'h8680_2000);
      chk("stall_irvalid", {31'b0, ir_valid}, 32'h1);
      chk("stall_memrd", {31'b0, mem_rd}, 32'h1);
    end
    stall = 1'b0;
    tick();
    chk("unstall_ir", ir, 32'h8880_3FF6);
    chk("unstall_irpc", irpc, 32'h80C);
    chk("unstall_addr", address, 32'h810);

    // Redirect beats stall; target low bits are dropped.
    stall = 1'b1; redirect = 1'b1; target = 32'h823;
    tick();
    stall = 1'b0; redirect = 1'b0;
    chk("redir_addr", address, 32'h820);
    chk("redir_irvalid", {31'b0, ir_valid}, 32'h0);
    chk("redir_ir_hold", ir, 32'h8880_3FF6);
    tick();
    chk("redir_ir", ir, 32'h8280_3800);
    chk("redir_irpc", irpc, 32'h820);
    chk("redir_irvalid1", {31'b0, ir_valid}, 32'h1);
    chk("redir_addr2", address, 32'h824);
    for (int i = 0; i < 4; i++) tick();
    chk("run_addr834", address, 32'h834);
    tick();
    chk("ba_ir", ir, 32'h10BF_FFFB);
    chk("ba_irvalid", {31'b0, ir_valid}, 32'h1);
`ifdef STATIC_BRANCH_EN
    chk("ba_next_addr", address, 32'h820);
    redirect = 1'b1; target = 32'h838;
    tick();
    redirect = 1'b0;
    chk("to_halt_addr", address, 32'h838);
`else
    chk("ba_next_addr", address, 32'h838);
`endif
    tick();
    chk("halt_halted", {31'b0, halted}, 32'h1);
    chk("halt_memrd", {31'b0, mem_rd}, 32'h0);
    chk("halt_irvalid", {31'b0, ir_valid}, 32'h0);
    chk("halt_addr", address, 32'h838);
    chk("halt_ir", ir, 32'h0);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk("halt_hold", {31'b0, halted}, 32'h1);
    chk("halt_hold_addr", address, 32'h838);

    // Leave HALT via redirect.
    redirect = 1'b1; target = 32'h800;
    tick();
    redirect = 1'b0;
    chk("resume_addr", address, 32'h800);
    chk("resume_memrd", {31'b0, mem_rd}, 32'h1);
    chk("resume_halted", {31'b0, halted}, 32'h0);
    chk("resume_irvalid", {31'b0, ir_valid}, 32'h0);
    tick();
    chk("resume_ir", ir, 32'h8280_2001);
    chk("resume_irvalid1", {31'b0, ir_valid}, 32'h1);
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_addr", address, 32'h818);

    // Asynchronous reset mid-cycle.
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", address, 32'h800);
    chk("arst_irvalid", {31'b0, ir_valid}, 32'h0);
    chk("arst_memrd", {31'b0, mem_rd}, 32'h0);
    chk("arst_ir", ir, 32'h0);

    // Redirect during IDLE, then PC wrap at the top of the address space.
    tick(); rst = 1'b0;
    redirect = 1'b1; target = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    chk("idle_redir_addr", address, 32'hFFFF_FFFC);
    chk("idle_redir_memrd", {31'b0, mem_rd}, 32'h1);
    tick();
    chk("wrap_addr", address, 32'h0);
    chk("wrap_ir", ir, 32'h0100_0000);
    chk("wrap_irpc", irpc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_halt", {31'b0, halted}, 32'h1);
    chk("wrap_halt_addr", address, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
